// File: rtl/fpu_arbiter_pkg.sv
// pa_fpu: shared FPU types and constants for the FPU and its request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FPU operation encoding, arbiter state encoding, default watchdog limit.
package pa_fpu;

  // FPU operation select, as consumed by fpu.operation.
  typedef enum logic [2:0] {
    op_add,
    op_sub,
    op_mul,
    op_div,
    op_sqrt,
    op_float_to_int,
    op_int_to_float
  } e_fpu_op;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP,
    DRAIN
  } e_fpu_arb_state;

  // Default number of RUN cycles tolerated before the watchdog aborts a command.
  localparam int FPU_ARB_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// rr_pick: round-robin winner selection over a request vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the grant.
// Ports: req_i request vector, ptr_i highest-priority index,
//        gnt_o one-hot grant, idx_o grant index, any_o at least one request set.
module rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  int          j;
  logic [IW-1:0] jw;

  // Walk upward from ptr_i with wrap; the first set bit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jw    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      jw = IW'(j);
      if (!any_o && req_i[jw]) begin
        any_o     = 1'b1;
        gnt_o[jw] = 1'b1;
        idx_o     = jw;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu between N_REQ requesters with round-robin grants.
// Latency: start one cycle after acceptance; response one cycle after fpu_cmd_end
//          (or TIMEOUT_CYCLES+1 cycles after the first RUN cycle on abort).
// Backpressure: req_ready pulses only in IDLE; other requests hold req_valid and wait.
// Ports: clk/arst (async, active-high); req_valid/req_a/req_b/req_op/req_ready
//        request channels; rsp_valid/rsp_result/rsp_error response strobe;
//        fpu_start/fpu_a/fpu_b/fpu_op drive the fpu; fpu_result/fpu_cmd_end/fpu_busy
//        come back from it.
module fpu_arbiter
  import pa_fpu::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = FPU_ARB_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0][31:0]  req_a,
  input  logic [N_REQ-1:0][31:0]  req_b,
  input  e_fpu_op [N_REQ-1:0]     req_op,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [31:0]             rsp_result,
  output logic                    rsp_error,
  output logic                    fpu_start,
  output logic [31:0]             fpu_a,
  output logic [31:0]             fpu_b,
  output e_fpu_op                 fpu_op,
  input  logic [31:0]             fpu_result,
  input  logic                    fpu_cmd_end,
  input  logic                    fpu_busy
);

  localparam int IW = $clog2(N_REQ);
  // Wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  e_fpu_arb_state state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  gidx_q, gidx_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  e_fpu_op        op_q, op_d;
  logic [CW-1:0]  wd_q, wd_d;
  logic [31:0]    result_q, result_d;
  logic           error_q, error_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= op_add;
      wd_q     <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      wd_q     <= wd_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    wd_d     = wd_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gidx_d   = pick_idx;
          a_d      = req_a[pick_idx];
          b_d      = req_b[pick_idx];
          op_d     = req_op[pick_idx];
          rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
          wd_d     = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        wd_d = wd_q + CW'(1);
        // Completion wins over an abort landing in the same cycle. wd_q counts
        // RUN cycles already elapsed, so the abort response lands exactly
        // TIMEOUT_CYCLES+1 cycles after the first RUN cycle.
        if (fpu_cmd_end) begin
          result_d = fpu_result;
          error_d  = 1'b0;
          state_d  = RESP;
        end else if (wd_q == CW'(TIMEOUT_CYCLES)) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // Hold off the next start until the fpu has fully wound down.
        if (!fpu_busy && !fpu_cmd_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state so an asynchronous reset clears them
  // at once; req_ready is also masked by arst since IDLE is the reset state.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && !arst) begin
      req_ready = pick_gnt;
    end
    if (state_q == RESP) begin
      rsp_valid[gidx_q] = 1'b1;
    end
  end

  assign fpu_start  = (state_q == RUN);
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign fpu_op     = op_q;
  assign rsp_result = result_q;
  assign rsp_error  = error_q;

endmodule
